// File: rtl/l1_dcache_ctrl_if.sv
// Memory-side bus of the L1 data cache: one outstanding request at a time,
// completed by a single-cycle ack pulse that carries read data.
interface l1_dcache_ctrl_if #(
  parameter int data_size = 32
);
  logic                 mem_req;
  logic                 mem_we;
  logic [data_size-1:0] mem_addr;
  logic [data_size-1:0] mem_wdata;
  logic                 mem_ack;
  logic [data_size-1:0] mem_rdata;

  // Cache controller side
  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  // Backing memory side
  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/l1_dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate L1 data cache controller.
// Load hits complete with no added cycles; load misses and every store
// stall the pipeline until the backing memory acknowledges.
module l1_dcache_ctrl #(
  parameter int data_size  = 32,
  parameter int index_bits = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 M_MemRead,
  input  logic                 M_MemWrite,
  input  logic [data_size-1:0] M_Addr,
  input  logic [data_size-1:0] M_Write_Data,
  output logic [data_size-1:0] M_DM_Read_Data,
  output logic                 stall,
  l1_dcache_ctrl_if.master     mem,
  output logic [15:0]          hit_count,
  output logic [15:0]          miss_count
);

  localparam int lines    = 2 ** index_bits;
  localparam int tag_bits = data_size - index_bits - 2;

  typedef enum logic [1:0] {IDLE, RMISS, WRITE, DONE} state_t;

  state_t state, next_state;

  logic [lines-1:0]     valid;
  logic [tag_bits-1:0]  tag_arr  [lines];
  logic [data_size-1:0] data_arr [lines];

  logic [data_size-1:0] ret_data;
  logic [data_size-1:0] lat_addr;
  logic [data_size-1:0] lat_data;
  logic                 done_load;

  logic [index_bits-1:0] cur_index;
  logic [tag_bits-1:0]   cur_tag;
  logic [index_bits-1:0] lat_index;
  logic [tag_bits-1:0]   lat_tag;
  logic                  hit;
  logic                  is_read;
  logic                  is_write;
  logic                  unused_addr_bits;

  assign cur_index = M_Addr[index_bits+1:2];
  assign cur_tag   = M_Addr[data_size-1:index_bits+2];
  assign lat_index = lat_addr[index_bits+1:2];
  assign lat_tag   = lat_addr[data_size-1:index_bits+2];
  assign hit       = valid[cur_index] && (tag_arr[cur_index] == cur_tag);

  // A simultaneous read and write request is handled as a write
  assign is_write  = M_MemWrite;
  assign is_read   = M_MemRead && !M_MemWrite;

  // Byte offset inside the word plays no role in a word-organised cache
  assign unused_addr_bits = ^M_Addr[1:0];

  // Bus address and data come only from latched registers, never from M_* inputs
  assign mem.mem_addr  = lat_addr;
  assign mem.mem_wdata = lat_data;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // Next-state decode plus stall, bus strobes and load data selection
  always_comb begin
    next_state     = state;
    stall          = 1'b0;
    mem.mem_req    = 1'b0;
    mem.mem_we     = 1'b0;
    M_DM_Read_Data = data_arr[cur_index];
    case (state)
      IDLE: begin
        if (is_write) begin
          stall      = 1'b1;
          next_state = WRITE;
        end else if (is_read && !hit) begin
          stall      = 1'b1;
          next_state = RMISS;
        end
      end
      RMISS: begin
        stall       = 1'b1;
        mem.mem_req = 1'b1;
        if (mem.mem_ack) next_state = DONE;
      end
      WRITE: begin
        stall       = 1'b1;
        mem.mem_req = 1'b1;
        mem.mem_we  = 1'b1;
        if (mem.mem_ack) next_state = DONE;
      end
      DONE: begin
        if (done_load) M_DM_Read_Data = ret_data;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Line arrays: write-hit update in IDLE, refill when a read miss is acknowledged
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= '0;
      for (int i = 0; i < lines; i++) begin
        tag_arr[i]  <= '0;
        data_arr[i] <= '0;
      end
    end else begin
      if (state == IDLE && is_write && hit)
        data_arr[cur_index] <= M_Write_Data;
      if (state == RMISS && mem.mem_ack) begin
        valid[lat_index]    <= 1'b1;
        tag_arr[lat_index]  <= lat_tag;
        data_arr[lat_index] <= mem.mem_rdata;
      end
    end
  end

  // Request latches, load return register and saturating hit/miss counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lat_addr   <= '0;
      lat_data   <= '0;
      ret_data   <= '0;
      done_load  <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (state == IDLE) begin
        if (is_write) begin
          lat_addr  <= {M_Addr[data_size-1:2], 2'b00};
          lat_data  <= M_Write_Data;
          done_load <= 1'b0;
        end else if (is_read && !hit) begin
          lat_addr  <= {M_Addr[data_size-1:2], 2'b00};
          done_load <= 1'b1;
          if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
        end else if (is_read && hit) begin
          if (hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
        end
      end
      if (state == RMISS && mem.mem_ack)
        ret_data <= mem.mem_rdata;
    end
  end

endmodule

// File: tb/tb_l1_dcache_ctrl.sv
// Self-checking bench for l1_dcache_ctrl. The reference model treats the
// cache as a set of resident word addresses in front of a flat memory: every
// load must return the current memory value, and hit/miss, stall length and
// counters follow from which words are resident.
module tb_l1_dcache_ctrl;

  localparam int DS         = 32;
  localparam int INDEX_BITS = 4;
  localparam int LINES      = 2 ** INDEX_BITS;

  logic          clk;
  logic          rst;
  logic          M_MemRead;
  logic          M_MemWrite;
  logic [DS-1:0] M_Addr;
  logic [DS-1:0] M_Write_Data;
  logic [DS-1:0] M_DM_Read_Data;
  logic          stall;
  logic [15:0]   hit_count;
  logic [15:0]   miss_count;

  l1_dcache_ctrl_if #(.data_size(DS)) mem_bus ();

  l1_dcache_ctrl #(.data_size(DS), .index_bits(INDEX_BITS)) dut (
    .clk            (clk),
    .rst            (rst),
    .M_MemRead      (M_MemRead),
    .M_MemWrite     (M_MemWrite),
    .M_Addr         (M_Addr),
    .M_Write_Data   (M_Write_Data),
    .M_DM_Read_Data (M_DM_Read_Data),
    .stall          (stall),
    .mem            (mem_bus),
    .hit_count      (hit_count),
    .miss_count     (miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] mem_model [logic [31:0]];
  bit          m_resident [LINES];
  logic [31:0] m_word     [LINES];
  int          m_hits;
  int          m_misses;

  int checks;
  int passes;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
  endtask

  function automatic logic [31:0] memRead(input logic [31:0] a);
    if (!mem_model.exists(a)) mem_model[a] = $urandom;
    return mem_model[a];
  endfunction

  function automatic int satInc(input int v, input int by);
    return (v + by > 65535) ? 65535 : v + by;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < LINES; i++) m_resident[i] = 1'b0;
    m_hits   = 0;
    m_misses = 0;
  endtask

  // One MEM-stage operation, called at a negedge; acts as the backing memory
  // with an ack n cycles after the request rises and returns at a negedge.
  task automatic applyStimulus(input bit rd, input bit wr, input logic [31:0] addr,
                               input logic [31:0] wdata, input int n);
    logic [31:0] waddr;
    logic [31:0] exp_data;
    int          idx;
    bit          exp_hit;
    bit          done_seen;
    int          stall_cnt;
    int          k;
    waddr    = {addr[31:2], 2'b00};
    idx      = int'(addr[INDEX_BITS+1:2]);
    exp_hit  = m_resident[idx] && (m_word[idx] == waddr);
    exp_data = memRead(waddr);
    M_MemRead    = rd;
    M_MemWrite   = wr;
    M_Addr       = addr;
    M_Write_Data = wdata;
    if (!rd && !wr) begin
      mem_bus.mem_ack   = 1'($urandom_range(0, 1));
      mem_bus.mem_rdata = $urandom;
    end
    #1;
    if (!rd && !wr) begin
      checkOutput("idle_stall", {31'd0, stall}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      mem_bus.mem_ack = 1'b0;
      return;
    end
    if (rd && !wr && exp_hit) begin
      checkOutput("hit_stall", {31'd0, stall}, 32'd0);
      checkOutput("hit_data", M_DM_Read_Data, exp_data);
      @(posedge clk);
      m_hits = satInc(m_hits, 1);
      @(negedge clk);
      checkOutput("hit_count", {16'd0, hit_count}, 32'(m_hits));
      return;
    end
    checkOutput("req_stall", {31'd0, stall}, 32'd1);
    if (!wr) m_misses = satInc(m_misses, 1);
    stall_cnt = 1;
    k         = 0;
    done_seen = 1'b0;
    while (!done_seen && stall_cnt < 40) begin
      @(posedge clk);
      @(negedge clk);
      mem_bus.mem_ack = 1'b0;
      if (stall == 1'b0) begin
        done_seen = 1'b1;
      end else begin
        stall_cnt++;
        if (k == 0) begin
          checkOutput("mem_req", {31'd0, mem_bus.mem_req}, 32'd1);
          checkOutput("mem_we", {31'd0, mem_bus.mem_we}, {31'd0, wr});
          checkOutput("mem_addr", mem_bus.mem_addr, waddr);
          if (wr) checkOutput("mem_wdata", mem_bus.mem_wdata, wdata);
        end
        if (k == n) begin
          mem_bus.mem_ack   = 1'b1;
          mem_bus.mem_rdata = wr ? $urandom : exp_data;
        end
        k++;
      end
    end
    checkOutput("stall_len", 32'(stall_cnt), 32'(n + 2));
    if (wr) begin
      mem_model[waddr] = wdata;
    end else begin
      m_resident[idx] = 1'b1;
      m_word[idx]     = waddr;
      checkOutput("done_data", M_DM_Read_Data, exp_data);
    end
    checkOutput("done_req", {31'd0, mem_bus.mem_req}, 32'd0);
    checkOutput("miss_count", {16'd0, miss_count}, 32'(m_misses));
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int stall_errs;
    int data_errs;
    logic [31:0] a;
    logic [31:0] exp_word;
    checks = 0;
    passes = 0;
    modelReset();
    rst               = 1'b0;
    M_MemRead         = 1'b0;
    M_MemWrite        = 1'b0;
    M_Addr            = '0;
    M_Write_Data      = '0;
    mem_bus.mem_ack   = 1'b0;
    mem_bus.mem_rdata = '0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_req", {31'd0, mem_bus.mem_req}, 32'd0);
    checkOutput("rst_we", {31'd0, mem_bus.mem_we}, 32'd0);
    checkOutput("rst_addr", mem_bus.mem_addr, 32'd0);
    checkOutput("rst_hits", {16'd0, hit_count}, 32'd0);
    checkOutput("rst_misses", {16'd0, miss_count}, 32'd0);
    rst = 1'b1;
    #1;
    checkOutput("rst_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);

    // Directed sequence: fill, hit, write-hit, write-miss, conflicts
    mem_model[32'h40] = 32'hDEADBEEF;
    applyStimulus(1'b1, 1'b0, 32'h40, 32'h0, 3);
    applyStimulus(1'b1, 1'b0, 32'h40, 32'h0, 0);
    applyStimulus(1'b0, 1'b1, 32'h40, 32'h12345678, 1);
    applyStimulus(1'b1, 1'b0, 32'h40, 32'h0, 0);
    applyStimulus(1'b0, 1'b1, 32'h80, 32'hCAFEF00D, 0);
    applyStimulus(1'b1, 1'b0, 32'h80, 32'h0, 2);
    applyStimulus(1'b1, 1'b0, 32'h40, 32'h0, 1);
    applyStimulus(1'b1, 1'b0, 32'h440, 32'h0, 0);
    applyStimulus(1'b1, 1'b0, 32'h40, 32'h0, 2);
    applyStimulus(1'b1, 1'b1, 32'h47, 32'hA5A5A5A5, 1);
    applyStimulus(1'b1, 1'b0, 32'h44, 32'h0, 0);

    // Reset while a read miss is outstanding
    M_MemRead = 1'b1;
    M_Addr    = 32'h440;
    #1;
    checkOutput("pre_rst_stall", {31'd0, stall}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    checkOutput("pre_rst_req", {31'd0, mem_bus.mem_req}, 32'd1);
    rst = 1'b0;
    #1;
    checkOutput("mid_rst_req", {31'd0, mem_bus.mem_req}, 32'd0);
    checkOutput("mid_rst_misses", {16'd0, miss_count}, 32'd0);
    M_MemRead = 1'b0;
    @(negedge clk);
    rst               = 1'b1;
    mem_bus.mem_ack   = 1'b1;
    mem_bus.mem_rdata = 32'h0BADF00D;
    #1;
    checkOutput("post_rst_stall", {31'd0, stall}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    mem_bus.mem_ack = 1'b0;
    checkOutput("late_ack_req", {31'd0, mem_bus.mem_req}, 32'd0);
    modelReset();
    applyStimulus(1'b1, 1'b0, 32'h440, 32'h0, 1);
    applyStimulus(1'b1, 1'b0, 32'h40, 32'h0, 0);

    // Randomized traffic over a small address pool to force hits and conflicts
    for (int t = 0; t < 300; t++) begin
      a = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom,
                    $urandom_range(0, 3));
    end

    // Hold a resident load long enough to saturate the hit counter
    applyStimulus(1'b1, 1'b0, 32'h8, 32'h0, 1);
    exp_word   = memRead(32'h8);
    stall_errs = 0;
    data_errs  = 0;
    M_MemRead  = 1'b1;
    M_MemWrite = 1'b0;
    M_Addr     = 32'h8;
    for (int c = 0; c < 65540; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (stall !== 1'b0) stall_errs++;
      if (M_DM_Read_Data !== exp_word) data_errs++;
    end
    m_hits = satInc(m_hits, 65540);
    checkOutput("sat_stalls", 32'(stall_errs), 32'd0);
    checkOutput("sat_data", 32'(data_errs), 32'd0);
    checkOutput("sat_hit_count", {16'd0, hit_count}, 32'(m_hits));
    M_MemRead = 1'b0;
    @(negedge clk);
    checkOutput("sat_hold", {16'd0, hit_count}, 32'hFFFF);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
